// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM state codes and
// small decode helpers used by the LSU datapath and its alignment logic.
package lsu_pkg;

   localparam int XLEN_DEF = 64;

   // Memory op codes; bit 3 set means store
   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LH  = 4'd1;
   localparam logic [3:0] OP_LW  = 4'd2;
   localparam logic [3:0] OP_LD  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_LWU = 4'd6;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;
   localparam logic [3:0] OP_SD  = 4'd11;

   // Size field encoding carried in op[1:0]
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   // FSM state codes
   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t ST_IDLE   = 2'd0;
   localparam lsu_state_t ST_REQ    = 2'd1;
   localparam lsu_state_t ST_WAIT_R = 2'd2;
   localparam lsu_state_t ST_RESP   = 2'd3;

   // Stores occupy codes 8..11; illegal codes are filtered separately
   function automatic logic is_store(input logic [3:0] op);
      return (op >= 4'd8);
   endfunction

   // Codes 7 and 12..15 have no defined meaning
   function automatic logic is_legal(input logic [3:0] op);
      return (op != 4'd7) && (op < 4'd12);
   endfunction

   // Byte-lane mask for an access of the given size, anchored at lane 0
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      case (sz)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Natural alignment: the offset must be a multiple of the access size
   function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] off);
      logic ok;
      case (sz)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = (off[0] == 1'b0);
         SZ_W:    ok = (off[1:0] == 2'b00);
         default: ok = (off == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave):
// req/gnt request phase followed by an rvalid data phase for loads.
interface lsu_if;

   logic        req;
   logic        we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [7:0]  wmask;
   logic        gnt;
   logic        rvalid;
   logic [63:0] rdata;

   modport master (
      output req, we, addr, wdata, wmask,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, wmask,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/lsu_load_align.sv
// Load formatter: picks the addressed bytes out of an 8-byte-aligned read
// word and sign- or zero-extends them to 64 bits. Purely combinational so a
// future cache path can share it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  off,
   input  logic [3:0]  op,
   output logic [63:0] data
);

   logic [63:0] shifted;

   // Bring the addressed byte to lane 0, then truncate and extend by op
   always_comb begin
      shifted = rdata >> {off, 3'b000};
      case (op)
         OP_LB:   data = {{56{shifted[7]}},  shifted[7:0]};
         OP_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
         OP_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
         OP_LD:   data = shifted;
         OP_LBU:  data = {56'd0, shifted[7:0]};
         OP_LHU:  data = {48'd0, shifted[15:0]};
         OP_LWU:  data = {32'd0, shifted[31:0]};
         default: data = 64'd0;
      endcase
   end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: accepts one memory op from the EXU, runs the req/gnt/rvalid
// handshake with data memory and returns formatted load data for writeback.
// Misaligned or illegal ops complete as a fault without touching memory.
module lsu_unit
   import lsu_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int MEM_AW = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [MEM_AW-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [4:0]      in_rd,
   lsu_if.master           mem,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            misalign,
   output logic            busy
);

   lsu_state_t  state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  wmask_q, wmask_d;
   logic [4:0]  rd_q, rd_d;
   logic [63:0] ld_data_q, ld_data_d;
   logic        fault_q, fault_d;

   logic [63:0] ld_fmt;
   logic        in_fault;

   lsu_load_align u_load_align (
      .rdata (mem.rdata),
      .off   (addr_q[2:0]),
      .op    (op_q),
      .data  (ld_fmt)
   );

   // Fault detection on the incoming op, used only at accept time
   always_comb begin
      in_fault = !is_legal(in_op) || !is_aligned(in_op[1:0], in_addr[2:0]);
   end

   // Next-state and capture logic for the access sequencer
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      rd_d      = rd_q;
      ld_data_d = ld_data_q;
      fault_d   = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d      = in_op;
               addr_d    = in_addr;
               rd_d      = in_rd;
               wdata_d   = in_wdata << {in_addr[2:0], 3'b000};
               wmask_d   = size_mask(in_op[1:0]) << in_addr[2:0];
               ld_data_d = 64'd0;
               fault_d   = in_fault;
               state_d   = in_fault ? ST_RESP : ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem.gnt) begin
               state_d = is_store(op_q) ? ST_RESP : ST_WAIT_R;
            end
         end
         ST_WAIT_R: begin
            if (mem.rvalid) begin
               ld_data_d = ld_fmt;
               state_d   = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and operand registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= 4'd0;
         addr_q    <= 64'd0;
         wdata_q   <= 64'd0;
         wmask_q   <= 8'd0;
         rd_q      <= 5'd0;
         ld_data_q <= 64'd0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         rd_q      <= rd_d;
         ld_data_q <= ld_data_d;
         fault_q   <= fault_d;
      end
   end

   // Memory request outputs; strobes only assert while the request is live
   always_comb begin
      mem.req   = (state_q == ST_REQ);
      mem.we    = (state_q == ST_REQ) && is_store(op_q);
      mem.addr  = {addr_q[63:3], 3'b000};
      mem.wdata = wdata_q;
      mem.wmask = (state_q == ST_REQ) ? wmask_q : 8'd0;
   end

   // Handshake and writeback outputs; data is zeroed for stores and faults
   always_comb begin
      in_ready = (state_q == ST_IDLE) && !rst;
      busy     = (state_q != ST_IDLE);
      wb_valid = (state_q == ST_RESP);
      misalign = (state_q == ST_RESP) && fault_q;
      wb_rd    = 5'd0;
      wb_data  = '0;
      if ((state_q == ST_RESP) && !fault_q && !is_store(op_q)) begin
         wb_rd   = rd_q;
         wb_data = ld_data_q;
      end
   end

endmodule

// File: tb/tb_lsu_unit.sv
// Bench for lsu_unit: directed scenarios plus randomized ops, checked against
// a byte-addressed reference memory and arithmetic expectations.
module tb_lsu_unit;
   import lsu_pkg::*;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic [4:0]  in_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        misalign;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   // Reference memory (updated from the op stream) and bench memory (updated
   // from what the DUT actually writes)
   logic [7:0] ref_bytes [logic [63:0]];
   logic [7:0] mem_bytes [logic [63:0]];

   lsu_if mem ();

   lsu_unit #(.XLEN(64), .MEM_AW(64)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_addr  (in_addr),
      .in_wdata (in_wdata),
      .in_rd    (in_rd),
      .mem      (mem),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .misalign (misalign),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic touch(input logic [63:0] a);
      logic [7:0] b;
      if (!ref_bytes.exists(a)) begin
         b = 8'($urandom);
         ref_bytes[a] = b;
         mem_bytes[a] = b;
      end
   endtask

   task automatic preset_word(input logic [63:0] a, input logic [63:0] w);
      for (int i = 0; i < 8; i++) begin
         ref_bytes[a + 64'(i)] = w[8*i +: 8];
         mem_bytes[a + 64'(i)] = w[8*i +: 8];
      end
   endtask

   task automatic bench_word(input logic [63:0] a, output logic [63:0] w);
      w = 64'd0;
      for (int i = 0; i < 8; i++) begin
         touch(a + 64'(i));
         w[8*i +: 8] = mem_bytes[a + 64'(i)];
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One complete op: drive it, play memory with the given delays, and check
   // every cycle until the unit is idle again
   task automatic apply_stimulus(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [4:0] rd, input int gnt_dly, input int rv_dly);
      int          nbytes;
      int          off;
      int          m;
      logic        legal;
      logic        fault;
      logic        store;
      logic [63:0] exp_load;
      logic [63:0] exp_addr;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_mask;
      logic [63:0] word;

      nbytes    = 1 << op[1:0];
      off       = int'(addr % 64'd8);
      legal     = (op != 4'd7) && (op < 4'd12);
      fault     = !legal || ((addr % 64'(nbytes)) != 64'd0);
      store     = (op >= 4'd8);
      exp_addr  = addr - 64'(off);
      m         = ((1 << nbytes) - 1) << off;
      exp_mask  = 8'(m);
      exp_wdata = wdata << (8 * off);
      exp_load  = 64'd0;
      if (!fault && !store) begin
         for (int i = 0; i < nbytes; i++) begin
            touch(addr + 64'(i));
            exp_load = exp_load | (64'(ref_bytes[addr + 64'(i)]) << (8 * i));
         end
         if (op < 4'd4 && nbytes < 8 && exp_load[8*nbytes-1]) begin
            exp_load = exp_load | ~((64'd1 << (8 * nbytes)) - 64'd1);
         end
      end

      check_output("ready_before_accept", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_op    = op;
      in_addr  = addr;
      in_wdata = wdata;
      in_rd    = rd;
      cycle();
      in_valid = 1'b0;
      in_op    = 4'($urandom);
      in_addr  = {$urandom, $urandom};
      in_wdata = {$urandom, $urandom};
      in_rd    = 5'($urandom);

      if (fault) begin
         check_output("fault_wb_valid", {63'd0, wb_valid}, 64'd1);
         check_output("fault_misalign", {63'd0, misalign}, 64'd1);
         check_output("fault_no_req", {63'd0, mem.req}, 64'd0);
         check_output("fault_wb_data", wb_data, 64'd0);
         check_output("fault_wb_rd", {59'd0, wb_rd}, 64'd0);
         check_output("fault_in_ready", {63'd0, in_ready}, 64'd0);
      end else begin
         for (int c = 0; c <= gnt_dly; c++) begin
            check_output("req_held", {63'd0, mem.req}, 64'd1);
            check_output("req_addr", mem.addr, exp_addr);
            check_output("req_we", {63'd0, mem.we}, {63'd0, store});
            check_output("req_busy", {63'd0, busy}, 64'd1);
            check_output("req_in_ready", {63'd0, in_ready}, 64'd0);
            check_output("req_no_wb", {63'd0, wb_valid}, 64'd0);
            if (store) begin
               check_output("store_wmask", {56'd0, mem.wmask}, {56'd0, exp_mask});
               check_output("store_wdata", mem.wdata, exp_wdata);
            end
            if (c == gnt_dly) begin
               mem.gnt    = 1'b1;
               mem.rvalid = 1'b1;
               mem.rdata  = {$urandom, $urandom};
               if (store) begin
                  for (int i = 0; i < 8; i++) begin
                     if (mem.wmask[i]) mem_bytes[mem.addr + 64'(i)] = mem.wdata[8*i +: 8];
                  end
               end
            end
            cycle();
            mem.gnt    = 1'b0;
            mem.rvalid = 1'b0;
         end
         if (store) begin
            for (int i = 0; i < nbytes; i++) ref_bytes[addr + 64'(i)] = wdata[8*i +: 8];
         end else begin
            for (int c = 0; c < rv_dly; c++) begin
               check_output("wait_no_req", {63'd0, mem.req}, 64'd0);
               check_output("wait_no_wb", {63'd0, wb_valid}, 64'd0);
               check_output("wait_busy", {63'd0, busy}, 64'd1);
               mem.gnt = (c == 0);
               cycle();
               mem.gnt = 1'b0;
            end
            check_output("wait_no_wb", {63'd0, wb_valid}, 64'd0);
            bench_word(exp_addr, word);
            mem.rvalid = 1'b1;
            mem.rdata  = word;
            cycle();
            mem.rvalid = 1'b0;
            mem.rdata  = {$urandom, $urandom};
         end
         check_output("resp_wb_valid", {63'd0, wb_valid}, 64'd1);
         check_output("resp_misalign", {63'd0, misalign}, 64'd0);
         check_output("resp_no_req", {63'd0, mem.req}, 64'd0);
         check_output("resp_wb_rd", {59'd0, wb_rd}, store ? 64'd0 : {59'd0, rd});
         check_output("resp_wb_data", wb_data, store ? 64'd0 : exp_load);
         check_output("resp_in_ready", {63'd0, in_ready}, 64'd0);
      end

      cycle();
      check_output("done_wb_pulse", {63'd0, wb_valid}, 64'd0);
      check_output("done_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      logic [3:0]  r_op;
      logic [63:0] r_addr;
      int          r_size;

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_op      = 4'd0;
      in_addr    = 64'd0;
      in_wdata   = 64'd0;
      in_rd      = 5'd0;
      mem.gnt    = 1'b0;
      mem.rvalid = 1'b0;
      mem.rdata  = 64'd0;

      // Reset state
      cycle();
      cycle();
      check_output("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check_output("rst_busy", {63'd0, busy}, 64'd0);
      check_output("rst_mem_req", {63'd0, mem.req}, 64'd0);
      check_output("rst_mem_we", {63'd0, mem.we}, 64'd0);
      check_output("rst_mem_wmask", {56'd0, mem.wmask}, 64'd0);
      check_output("rst_mem_addr", mem.addr, 64'd0);
      check_output("rst_mem_wdata", mem.wdata, 64'd0);
      check_output("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      check_output("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
      check_output("rst_wb_data", wb_data, 64'd0);
      check_output("rst_misalign", {63'd0, misalign}, 64'd0);
      rst = 1'b0;
      cycle();

      // Stray gnt while idle must not start anything
      mem.gnt = 1'b1;
      cycle();
      mem.gnt = 1'b0;
      check_output("idle_gnt_ignored", {63'd0, busy}, 64'd0);

      // Aligned LD, immediate gnt, rvalid next cycle
      preset_word(BASE, 64'h1122_3344_5566_7788);
      apply_stimulus(OP_LD, BASE, 64'd0, 5'd7, 0, 0);

      // LB / LBU of a byte with the top bit set
      preset_word(BASE + 64'h20, 64'h0123_4567_80AB_CDEF);
      apply_stimulus(OP_LB, BASE + 64'h23, 64'd0, 5'd3, 0, 0);
      apply_stimulus(OP_LBU, BASE + 64'h23, 64'd0, 5'd3, 0, 0);

      // SH into the top half-word lanes
      apply_stimulus(OP_SH, BASE + 64'h6, 64'h0000_0000_0000_BEEF, 5'd9, 0, 0);

      // Misaligned LW and illegal codes fault without a request
      apply_stimulus(OP_LW, BASE + 64'h2, 64'd0, 5'd4, 0, 0);
      apply_stimulus(4'd7, BASE, 64'd0, 5'd4, 0, 0);
      apply_stimulus(4'd12, BASE, 64'd0, 5'd4, 0, 0);

      // LD with gnt withheld for four cycles
      apply_stimulus(OP_LD, BASE + 64'h8, 64'd0, 5'd11, 4, 2);

      // Load to x0 still runs the handshake but reports rd 0
      apply_stimulus(OP_LW, BASE + 64'h4, 64'd0, 5'd0, 1, 1);

      // Reset while waiting for read data
      in_valid = 1'b1;
      in_op    = OP_LD;
      in_addr  = BASE + 64'h18;
      in_rd    = 5'd5;
      cycle();
      in_valid = 1'b0;
      mem.gnt  = 1'b1;
      cycle();
      mem.gnt  = 1'b0;
      check_output("rstmid_busy_before", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      cycle();
      check_output("rstmid_busy", {63'd0, busy}, 64'd0);
      check_output("rstmid_req", {63'd0, mem.req}, 64'd0);
      check_output("rstmid_wb_valid", {63'd0, wb_valid}, 64'd0);
      check_output("rstmid_in_ready", {63'd0, in_ready}, 64'd0);
      rst        = 1'b0;
      mem.rvalid = 1'b1;
      mem.rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      cycle();
      mem.rvalid = 1'b0;
      check_output("stray_rvalid_wb", {63'd0, wb_valid}, 64'd0);
      check_output("stray_rvalid_busy", {63'd0, busy}, 64'd0);
      check_output("stray_rvalid_ready", {63'd0, in_ready}, 64'd1);
      cycle();
      check_output("stray_rvalid_wb2", {63'd0, wb_valid}, 64'd0);

      // SD then LD to the same address through the bench memory
      apply_stimulus(OP_SD, BASE + 64'h30, 64'hCAFE_F00D_1234_5678, 5'd1, 1, 0);
      apply_stimulus(OP_LD, BASE + 64'h30, 64'd0, 5'd2, 0, 1);

      // Randomized mix of loads, stores and faults over a small window
      for (int n = 0; n < 80; n++) begin
         r_op   = 4'($urandom_range(0, 15));
         r_size = 1 << r_op[1:0];
         r_addr = BASE + 64'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~64'(r_size - 1);
         apply_stimulus(r_op, r_addr, {$urandom, $urandom}, 5'($urandom),
                        $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
